// File: rtl/memarb_pkg.sv
// Shared definitions for the IF/LS memory port arbiter: FSM state encoding
// and the meaning of the mux select bit.
package memarb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_IF  = 3'd1,
        REQ_LS  = 3'd2,
        WAIT_IF = 3'd3,
        WAIT_LS = 3'd4
    } state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_LS = 1'b1;

endpackage

// File: rtl/mux2to1Nbit.sv
// N-bit 2:1 mux used to steer one field (address, write data or byte
// enables) from either the fetch side or the load/store side onto the port.
module mux2to1Nbit
    import memarb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         sel,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    output logic [N-1:0] out_y
);

    assign out_y = (sel == SEL_LS) ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch stage (IF) and the
// load/store stage (LS), one transaction at a time:
// arbitrate -> issue (wait for mem_ready) -> wait for mem_rvalid -> route.
// Build option MEM_ARB_RR_FAIR_EN: round-robin on contention using a
// last_grant flop; without it LS always wins on contention.
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_be,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    output logic [DATA_W-1:0]     rdata_o,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  sel,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    // A fetch never writes: its side of the data/enable muxes is fixed.
    localparam logic [DATA_W-1:0] IF_WDATA = '0;
    localparam logic [BE_W-1:0]   IF_BE    = '1;

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   ls_wins;

`ifdef MEM_ARB_RR_FAIR_EN
    logic   last_grant_q, last_grant_d;
`endif

    // Arbitration decision used when leaving IDLE.
    always_comb begin
`ifdef MEM_ARB_RR_FAIR_EN
        // On contention, the side that was not granted last time wins.
        ls_wins = ls_req && (!if_req || (last_grant_q == SEL_IF));
`else
        // LS carries the older instruction, so it always wins contention.
        ls_wins = ls_req;
`endif
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
`ifdef MEM_ARB_RR_FAIR_EN
        last_grant_d = last_grant_q;
`endif
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;

        unique case (state_q)
            IDLE: begin
                // sel only moves here, so it is stable for a whole transaction.
                if (ls_wins) begin
                    state_d = REQ_LS;
                    sel_d   = SEL_LS;
                end else if (if_req) begin
                    state_d = REQ_IF;
                    sel_d   = SEL_IF;
                end
            end
            REQ_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    if_gnt  = 1'b1;
                    state_d = WAIT_IF;
`ifdef MEM_ARB_RR_FAIR_EN
                    last_grant_d = SEL_IF;
`endif
                end
            end
            REQ_LS: begin
                mem_req = 1'b1;
                mem_we  = ls_we;
                if (mem_ready) begin
                    ls_gnt  = 1'b1;
                    state_d = WAIT_LS;
`ifdef MEM_ARB_RR_FAIR_EN
                    last_grant_d = SEL_LS;
`endif
                end
            end
            WAIT_IF: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_LS: begin
                if (mem_rvalid) begin
                    ls_rvalid = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, select and fairness registers; reset drops any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_IF;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

`ifdef MEM_ARB_RR_FAIR_EN
    // Remembers which side received the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= SEL_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    mux2to1Nbit #(.N(ADDR_W)) u_addr_mux (
        .sel   (sel_q),
        .in0   (if_addr),
        .in1   (ls_addr),
        .out_y (mem_addr)
    );

    mux2to1Nbit #(.N(DATA_W)) u_wdata_mux (
        .sel   (sel_q),
        .in0   (IF_WDATA),
        .in1   (ls_wdata),
        .out_y (mem_wdata)
    );

    mux2to1Nbit #(.N(BE_W)) u_be_mux (
        .sel   (sel_q),
        .in0   (IF_BE),
        .in1   (ls_be),
        .out_y (mem_be)
    );

    assign sel     = sel_q;
    assign busy    = (state_q != IDLE);
    assign rdata_o = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Inputs change 1 ns after the
// rising edge, outputs are sampled at the falling edge. Expected responses
// are queued when a request is granted and popped when rvalid appears.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

`ifdef MEM_ARB_RR_FAIR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [BW-1:0] ls_be;
    logic          mem_req, mem_we, mem_ready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, rdata_o;
    logic [BW-1:0] mem_be;
    logic          sel, busy;

    typedef struct {
        logic          side;   // 0 = IF, 1 = LS
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic side_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .rdata_o(rdata_o), .mem_rdata(mem_rdata), .sel(sel), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters must hold req while the port is issuing for them.
    always @(negedge clk) begin
        if (!rst && mem_req && ((sel == 1'b0 && !if_req) || (sel == 1'b1 && !ls_req))) begin
            n_fail++;
            $display("FAIL req_dropped: sel=%b if_req=%b ls_req=%b while mem_req=1", sel, if_req, ls_req);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0;
        ls_wdata = '0; ls_be = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        if_req = 1; ls_req = 1; mem_ready = 1; mem_rvalid = 1;
        repeat (2) @(posedge clk);
        #5;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (sel !== 1'b0)       begin n_fail++; $display("FAIL reset_sel: got %b want 0", sel); end
        n_checks++; if (mem_req !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if ({if_gnt, ls_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {if_gnt, ls_gnt}); end
        n_checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {if_rvalid, ls_rvalid}); end
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        exp_t e;
        next_cycle();
        if_req = 1; if_addr = 32'h100; mem_ready = 1;
        exp_q.push_back('{side: 1'b0, data: 32'h0000_0013});
        mid();
        n_checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_c0: busy=%b mem_req=%b if_gnt=%b want 0/0/0", busy, mem_req, if_gnt); end
        next_cycle(); mid();
        n_checks++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt: if_gnt=%b ls_gnt=%b want 1/0", if_gnt, ls_gnt); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_port: mem_req=%b addr=%h want 1/00000100", mem_req, mem_addr); end
        n_checks++; if (sel !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL fetch_fields: sel=%b we=%b be=%h wdata=%h want 0/0/f/0", sel, mem_we, mem_be, mem_wdata); end
        next_cycle();
        if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        mid();
        n_checks++; if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid: if_rv=%b ls_rv=%b mem_req=%b want 1/0/0", if_rvalid, ls_rvalid, mem_req); end
        if (if_rvalid || ls_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL fetch_sb: unexpected response %h, none pending", rdata_o); end
            else begin
                e = exp_q.pop_front();
                if (ls_rvalid !== e.side || rdata_o !== e.data) begin n_fail++; $display("FAIL fetch_sb: side=%b data=%h want side=%b data=%h", ls_rvalid, rdata_o, e.side, e.data); end
            end
        end
        next_cycle();
        mem_rvalid = 0;
        mid();
        n_checks++; if (busy !== 1'b0 || if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_done: busy=%b if_rv=%b want 0/0", busy, if_rvalid); end
    endtask

    task automatic test_store_stall();
        exp_t e;
        int   req_cycles = 0;
        next_cycle();
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'hF; mem_ready = 0;
        mid();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL store_c0: mem_req=%b want 0", mem_req); end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mem_ready = (i == 3);
            mid();
            if (mem_req) req_cycles++;
            n_checks++; if (mem_req !== 1'b1 || sel !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL store_hold%0d: mem_req=%b sel=%b we=%b want 1/1/1", i, mem_req, sel, mem_we); end
            n_checks++; if (mem_addr !== 32'h2000 || mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'hF) begin n_fail++; $display("FAIL store_fields%0d: addr=%h wdata=%h be=%h want 00002000/deadbeef/f", i, mem_addr, mem_wdata, mem_be); end
            n_checks++; if (ls_gnt !== (i == 3) || if_gnt !== 1'b0) begin n_fail++; $display("FAIL store_gnt%0d: ls_gnt=%b if_gnt=%b want %b/0", i, ls_gnt, if_gnt, (i == 3)); end
            if (ls_gnt) exp_q.push_back('{side: 1'b1, data: 32'h0});
        end
        n_checks++; if (req_cycles !== 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d want 4", req_cycles); end
        next_cycle();
        ls_req = 0; ls_we = 0; mem_ready = 0;
        mid();
        n_checks++; if (ls_rvalid !== 1'b0 || busy !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL store_wait: ls_rv=%b busy=%b mem_req=%b want 0/1/0", ls_rvalid, busy, mem_req); end
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'h0;
        mid();
        n_checks++; if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin n_fail++; $display("FAIL store_ack: ls_rv=%b if_rv=%b want 1/0", ls_rvalid, if_rvalid); end
        if (if_rvalid || ls_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL store_sb: unexpected response, none pending"); end
            else begin
                e = exp_q.pop_front();
                if (ls_rvalid !== e.side) begin n_fail++; $display("FAIL store_sb: side=%b want %b", ls_rvalid, e.side); end
            end
        end
        next_cycle();
        mem_rvalid = 0;
        mid();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL store_done: busy=%b want 0", busy); end
    endtask

    task automatic test_contention();
        exp_t          e;
        logic          s;
        int            grants = 0;
        logic [AW-1:0] last_addr = '0;
        next_cycle();
        rst = 1; drive_idle();
        next_cycle();
        rst = 0;
        exp_q.delete(); side_q.delete();
        for (int i = 0; i < 4; i++) side_q.push_back(RR ? ((i % 2) == 0) : 1'b1);
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            if_req = (grants < 4); ls_req = (grants < 4);
            if_addr = 32'h180; ls_addr = 32'h80; ls_we = 0;
            mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hC0DE_0000 | last_addr;
            mid();
            n_checks++; if ((if_gnt && ls_gnt) || (if_rvalid && ls_rvalid)) begin n_fail++; $display("FAIL cont_exclusive: gnt=%b%b rvalid=%b%b", if_gnt, ls_gnt, if_rvalid, ls_rvalid); end
            if (if_rvalid || ls_rvalid) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL cont_sb: unexpected response %h", rdata_o); end
                else begin
                    e = exp_q.pop_front();
                    if (ls_rvalid !== e.side || rdata_o !== e.data) begin n_fail++; $display("FAIL cont_sb: side=%b data=%h want side=%b data=%h", ls_rvalid, rdata_o, e.side, e.data); end
                end
            end
            if (if_gnt || ls_gnt) begin
                n_checks++;
                if (side_q.size() == 0) begin n_fail++; $display("FAIL cont_order: extra grant ls_gnt=%b", ls_gnt); end
                else begin
                    s = side_q.pop_front();
                    if (ls_gnt !== s) begin n_fail++; $display("FAIL cont_order: grant %0d ls_gnt=%b want %b", grants, ls_gnt, s); end
                end
                n_checks++; if (mem_addr !== (ls_gnt ? 32'h80 : 32'h180)) begin n_fail++; $display("FAIL cont_addr: addr=%h ls_gnt=%b", mem_addr, ls_gnt); end
                exp_q.push_back('{side: ls_gnt, data: 32'hC0DE_0000 | mem_addr});
                last_addr = mem_addr;
                grants++;
            end
            if (grants == 4 && !busy && exp_q.size() == 0) break;
        end
        drive_idle();
        n_checks++; if (grants !== 4) begin n_fail++; $display("FAIL cont_count: got %0d grants want 4", grants); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL cont_pending: %0d responses outstanding want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        next_cycle();
        ls_req = 1; ls_we = 0; ls_addr = 32'h40; mem_ready = 1;
        mid();
        next_cycle(); mid();
        n_checks++; if (ls_gnt !== 1'b1) begin n_fail++; $display("FAIL rstw_gnt: ls_gnt=%b want 1", ls_gnt); end
        next_cycle();
        ls_req = 0; mem_ready = 0;
        mid();
        n_checks++; if (busy !== 1'b1 || sel !== 1'b1 || ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstw_wait: busy=%b sel=%b ls_rv=%b want 1/1/0", busy, sel, ls_rvalid); end
        next_cycle();
        rst = 1;
        mid();
        n_checks++; if (busy !== 1'b0 || sel !== 1'b0) begin n_fail++; $display("FAIL rstw_in_reset: busy=%b sel=%b want 0/0", busy, sel); end
        next_cycle();
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
        mid();
        n_checks++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstw_late_rvalid: ls_rv=%b if_rv=%b busy=%b want 0/0/0", ls_rvalid, if_rvalid, busy); end
        next_cycle();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h300; mem_ready = 1;
        exp_q.push_back('{side: 1'b0, data: 32'h0000_0077});
        mid();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstw_idle: busy=%b want 0", busy); end
        next_cycle(); mid();
        n_checks++; if (if_gnt !== 1'b1 || sel !== 1'b0 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL rstw_fetch_gnt: if_gnt=%b sel=%b addr=%h want 1/0/00000300", if_gnt, sel, mem_addr); end
        next_cycle();
        if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0077;
        mid();
        n_checks++; if (if_rvalid !== 1'b1) begin n_fail++; $display("FAIL rstw_fetch_rv: if_rv=%b want 1", if_rvalid); end
        if (if_rvalid || ls_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstw_sb: unexpected response %h", rdata_o); end
            else begin
                e = exp_q.pop_front();
                if (ls_rvalid !== e.side || rdata_o !== e.data) begin n_fail++; $display("FAIL rstw_sb: side=%b data=%h want side=%b data=%h", ls_rvalid, rdata_o, e.side, e.data); end
            end
        end
        next_cycle();
        mem_rvalid = 0;
        mid();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstw_done: busy=%b want 0", busy); end
    endtask

    task automatic test_spurious();
        exp_t e;
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'h0000_FFFF;
        mid();
        n_checks++; if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL spur_idle_rv: if_rv=%b ls_rv=%b want 0/0", if_rvalid, ls_rvalid); end
        next_cycle(); mid();
        n_checks++; if (busy !== 1'b0 || if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL spur_idle_state: busy=%b rv=%b%b want 0/00", busy, if_rvalid, ls_rvalid); end
        next_cycle();
        if_req = 1; if_addr = 32'h500; mem_ready = 0;
        mid();
        for (int i = 0; i < 2; i++) begin
            next_cycle(); mid();
            n_checks++; if (mem_req !== 1'b1 || if_gnt !== 1'b0 || if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL spur_req%0d: mem_req=%b if_gnt=%b rv=%b%b want 1/0/00", i, mem_req, if_gnt, if_rvalid, ls_rvalid); end
        end
        next_cycle();
        mem_rvalid = 0; mem_ready = 1;
        exp_q.push_back('{side: 1'b0, data: 32'h0000_0055});
        mid();
        n_checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL spur_gnt: if_gnt=%b addr=%h want 1/00000500", if_gnt, mem_addr); end
        next_cycle();
        if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0055;
        mid();
        n_checks++;
        if (!if_rvalid || exp_q.size() == 0) begin n_fail++; $display("FAIL spur_sb: if_rv=%b pending=%0d want 1/1", if_rvalid, exp_q.size()); end
        else begin
            e = exp_q.pop_front();
            if (ls_rvalid !== e.side || rdata_o !== e.data) begin n_fail++; $display("FAIL spur_sb: side=%b data=%h want side=%b data=%h", ls_rvalid, rdata_o, e.side, e.data); end
        end
        next_cycle();
        mem_rvalid = 0;
        mid();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spur_done: busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        exp_t          e;
        logic [AW-1:0] addrs[3];
        logic [AW-1:0] last_addr = '0;
        int            k = 0;
        int            last_gnt = -1;
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        exp_q.delete();
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            if_req = (k < 3); if_addr = (k < 3) ? addrs[k] : '0;
            mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1000_0000 | last_addr;
            mid();
            if (mem_req) begin
                n_checks++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin n_fail++; $display("FAIL b2b_fields: we=%b be=%h want 0/f", mem_we, mem_be); end
            end
            if (if_rvalid || ls_rvalid) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb: unexpected response %h", rdata_o); end
                else begin
                    e = exp_q.pop_front();
                    if (ls_rvalid !== e.side || rdata_o !== e.data) begin n_fail++; $display("FAIL b2b_sb: side=%b data=%h want side=%b data=%h", ls_rvalid, rdata_o, e.side, e.data); end
                end
            end
            if (if_gnt) begin
                n_checks++; if (mem_addr !== addrs[k]) begin n_fail++; $display("FAIL b2b_addr: addr=%h want %h", mem_addr, addrs[k]); end
                if (last_gnt >= 0) begin
                    n_checks++; if (c - last_gnt !== 3) begin n_fail++; $display("FAIL b2b_spacing: %0d cycles between grants want 3", c - last_gnt); end
                end
                exp_q.push_back('{side: 1'b0, data: 32'h1000_0000 | mem_addr});
                last_addr = mem_addr;
                last_gnt = c;
                k++;
            end
            if (k == 3 && !busy && exp_q.size() == 0) break;
        end
        drive_idle();
        n_checks++; if (k !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d grants want 3", k); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_pending: %0d responses outstanding want 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single_fetch();
        test_store_stall();
        test_contention();
        test_reset_mid_wait();
        test_spurious();
        test_back_to_back();
        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
